decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
Parametrised successor to the combinational N-way decoder. Decodes up to FETCH_WIDTH fetched instructions per cycle and stores the decoded packets in a circular instruction buffer of DEPTH entries. It presents up to DISPATCH_WIDTH oldest packets in program order to dispatch. Sits between fetch and dispatch/rename, decoupling fetch bandwidth from dispatch bandwidth. Adds valid-lane compaction, back-pressure, flush and halt-fencing.

Parameters:
FETCH_WIDTH, 2, instructions offered per cycle by fetch
DISPATCH_WIDTH, 2, packets presented per cycle to dispatch
DEPTH, 8, buffer entries; power of two, >= max(FETCH_WIDTH, DISPATCH_WIDTH)
XLEN, 32, PC width
REG_BITS, 5, architectural register index width

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  mispredict/exception squash; empties buffer
in_valid  in  FETCH_WIDTH  per-lane fetch valid; may be sparse
in_PC  in  FETCH_WIDTH x XLEN  per-lane PC
in_inst  in  FETCH_WIDTH x 32 (INST)  per-lane instruction
in_ready  out  1  buffer accepts the full fetch group this cycle
out_valid  out  DISPATCH_WIDTH  thermometer-coded; lane k valid iff count > k
out_pkt  out  DISPATCH_WIDTH x DECODED_PACKET  PC, NPC, inst, src1, src2, dest, is_branch, ld_st, halt, illegal
dispatch_count  in  clog2(DISPATCH_WIDTH+1)  packets consumed this cycle, from lane 0 upward
count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: head = tail = 0, count = 0, halt_seen = 0. Consequently out_valid = 0 and in_ready = 1. out_pkt content is don't-care while invalid.
- Decode is combinational per fetch lane, before enqueue:
  - LUI, AUIPC, JAL: dest = rd.
  - JALR: dest = rd, src1 = rs1.
  - Branches: is_branch = 1, src1 = rs1, src2 = rs2.
  - Loads: ld_st = 2'b10, dest = rd, src1 = rs1.
  - Stores: ld_st = 2'b01, src1 = rs1, src2 = rs2.
  - OP-IMM: dest = rd, src1 = rs1.
  - OP and RV32M MUL*: dest = rd, src1 = rs1, src2 = rs2.
  - CSRRW/S/C: legal, no operands.
  - WFI: halt = 1.
  - Anything else: illegal = 1.
  - Unused fields are 0. NPC = PC + 4 (mod 2^XLEN).
- Enqueue: fires when in_ready && !flush.
  - Valid lanes are compacted in ascending lane order into tail, tail+1, and so on. Pointers wrap mod DEPTH.
  - enq_n = number of valid lanes written.
- in_ready = (DEPTH - count >= FETCH_WIDTH) && !halt_seen. It is computed from registered count only; same-cycle dequeue does not count toward free space.
- Halt fencing:
  - If an accepted lane decodes as halt, that lane is enqueued. Higher-numbered lanes in the same group are dropped.
  - halt_seen is set next cycle, which holds in_ready = 0.
  - halt_seen clears only on reset or flush.
- Illegal instructions are enqueued normally with illegal = 1 and do not stop the queue.
- Dequeue: head advances by dispatch_count.
  - dispatch_count > count is a protocol error. Simulation assertion fires; RTL clamps to count.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n. Full-to-full and empty-to-empty transitions must be exact.
- Latency: an instruction accepted in cycle t appears on out_pkt in cycle t+1 at the earliest. There is no combinational in-to-out path.
- Flush has priority over enqueue and dequeue. Next cycle: head = tail = 0, count = 0, halt_seen = 0, out_valid = 0. Same-cycle inputs are ignored.
- Reset has priority over flush. Reset mid-operation discards all contents.
- out_pkt[k] = entry[(head + k) mod DEPTH].

Decomposition:
- Shared package: DECODED_PACKET struct, LD_ST_TYPE enum (NONE = 00, STORE = 01, LOAD = 10), clog2-derived width constants. INST and the RV32 opcode macros are reused from existing headers.
- One natural sub-module: decode_lane, the combinational single-instruction decoder. It is instantiated FETCH_WIDTH times. Compaction, pointers and the halt fence live in decode_queue.

Test Plan:
- Reset, then FETCH_WIDTH=2 group {ADDI x1,x2,5 @PC 0x0; SW x3,4(x4) @0x4} with dispatch_count = 0 -> next cycle out_valid = 2'b11, count = 2.
  - pkt0: dest = 1, src1 = 2, src2 = 0, NPC = 0x4.
  - pkt1: ld_st = 01, src1 = 4, src2 = 3, dest = 0.
- Sparse lanes in_valid = 2'b10 with LW x5,0(x6) -> stored in a single entry, count += 1, pkt0 is the LW with ld_st = 10.
- Fill DEPTH = 8 with dispatch_count = 0 -> in_ready drops at count = 7. At count = 6, enqueue 2 with dispatch_count = 2 -> count stays 6. Wrap-around of head and tail is exercised over 20 cycles against a scoreboard.
- Group {WFI, ADD} -> only WFI enqueued, ADD dropped; in_ready = 0 thereafter. Flush -> count = 0, in_ready = 1 next cycle.
- Flush asserted together with valid input and dispatch_count = 2 -> next cycle count = 0, nothing from that cycle enqueued.
- Undefined opcode 0xFFFFFFFF -> enqueued with illegal = 1; a following ADDI is still enqueued and dispatched in order.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: types and constants shared by the decode queue, its
// per-lane decoder, the bus interface and the bench.
//   decoded_packet_t : one decoded instruction as stored in the buffer
//   ld_st_type_e     : memory access class of a packet
//   OPC_*            : RV32 major opcodes recognised by the decoder
package decode_queue_pkg;

  localparam int XLEN     = 32;
  localparam int REG_BITS = 5;
  localparam int INST_W   = 32;

  typedef logic [INST_W-1:0] inst_t;

  typedef enum logic [1:0] {
    LD_ST_NONE  = 2'b00,
    LD_ST_STORE = 2'b01,
    LD_ST_LOAD  = 2'b10
  } ld_st_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam inst_t INST_WFI = 32'h1050_0073;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     npc;
    inst_t               inst;
    logic [REG_BITS-1:0] src1;
    logic [REG_BITS-1:0] src2;
    logic [REG_BITS-1:0] dest;
    logic                is_branch;
    ld_st_type_e         ld_st;
    logic                halt;
    logic                illegal;
  } decoded_packet_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and dispatch-side signals of the decode queue.
//   flush          : squash, empties the queue
//   in_valid/in_pc/in_inst : fetch group, one slot per fetch lane
//   in_ready       : whole fetch group can be accepted this cycle
//   out_valid/out_pkt : oldest packets, thermometer-coded valid
//   dispatch_count : packets consumed this cycle from lane 0 upward
//   count          : current occupancy
// slave = the queue, master = the fetch/dispatch environment.
interface decode_queue_if
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int DEPTH          = 8
) ();
  localparam int DC_W  = $clog2(DISPATCH_WIDTH + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                                  flush;
  logic [FETCH_WIDTH-1:0]                in_valid;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]      in_pc;
  logic [FETCH_WIDTH-1:0][INST_W-1:0]    in_inst;
  logic                                  in_ready;
  logic [DISPATCH_WIDTH-1:0]             out_valid;
  decoded_packet_t [DISPATCH_WIDTH-1:0]  out_pkt;
  logic [DC_W-1:0]                       dispatch_count;
  logic [CNT_W-1:0]                      count;

  modport master (
    output flush, in_valid, in_pc, in_inst, dispatch_count,
    input  in_ready, out_valid, out_pkt, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, dispatch_count,
    output in_ready, out_valid, out_pkt, count
  );
endinterface

// File: rtl/decode_lane.sv
// decode_lane: combinational RV32IM decoder for one fetch lane.
//   pc, inst : fetched instruction and its address
//   pkt      : decoded packet; operand fields a class does not use are 0
module decode_lane
  import decode_queue_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  inst_t           inst,
  output decoded_packet_t pkt
);
  logic [6:0]          opc;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [REG_BITS-1:0] rd, rs1, rs2;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign f7  = inst[31:25];

  always_comb begin
    pkt       = '0;
    pkt.pc    = pc;
    pkt.npc   = pc + XLEN'(4);
    pkt.inst  = inst;
    pkt.ld_st = LD_ST_NONE;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: pkt.dest = rd;
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          pkt.dest = rd;
          pkt.src1 = rs1;
        end else pkt.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3 inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111}) begin
          pkt.is_branch = 1'b1;
          pkt.src1      = rs1;
          pkt.src2      = rs2;
        end else pkt.illegal = 1'b1;
      end
      OPC_LOAD: begin
        if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          pkt.ld_st = LD_ST_LOAD;
          pkt.dest  = rd;
          pkt.src1  = rs1;
        end else pkt.illegal = 1'b1;
      end
      OPC_STORE: begin
        if (f3 inside {3'b000, 3'b001, 3'b010}) begin
          pkt.ld_st = LD_ST_STORE;
          pkt.src1  = rs1;
          pkt.src2  = rs2;
        end else pkt.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // shift-immediates carry a funct7; every other funct3 is a plain imm
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000))
          pkt.illegal = 1'b1;
        else begin
          pkt.dest = rd;
          pkt.src1 = rs1;
        end
      end
      OPC_OP: begin
        if (f7 == 7'b0000000 || f7 == 7'b0000001 ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          pkt.dest = rd;
          pkt.src1 = rs1;
          pkt.src2 = rs2;
        end else pkt.illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (inst == INST_WFI) pkt.halt = 1'b1;
        else if (!(f3 inside {3'b001, 3'b010, 3'b011})) pkt.illegal = 1'b1;
      end
      default: pkt.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes up to FETCH_WIDTH instructions per cycle into a
// DEPTH-entry circular buffer and presents the DISPATCH_WIDTH oldest packets
// in program order.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : fetch group in, dispatch window out, flush, occupancy
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int DEPTH          = 8
) (
  input  logic           clock,
  input  logic           reset,
  decode_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FW_C    = CNT_W'(FETCH_WIDTH);

  logic [FETCH_WIDTH-1:0][XLEN-1:0]   lane_pc;
  logic [FETCH_WIDTH-1:0][INST_W-1:0] lane_inst;
  decoded_packet_t [FETCH_WIDTH-1:0]  dec_pkt;

  assign lane_pc   = bus.in_pc;
  assign lane_inst = bus.in_inst;

  decode_lane u_lane [FETCH_WIDTH-1:0] (
    .pc   (lane_pc),
    .inst (lane_inst),
    .pkt  (dec_pkt)
  );

  decoded_packet_t  mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt;
  logic             halt_seen;

  logic                   ready, enq_fire, halt_in, blocked;
  logic [FETCH_WIDTH-1:0] keep;
  logic [PTR_W-1:0]       wr_ptr [FETCH_WIDTH];
  logic [CNT_W-1:0]       keep_n, enq_n, deq_n, dc_ext;

  // free space is judged on registered occupancy only, so a same-cycle
  // dequeue never creates room for this cycle's fetch group
  assign ready    = ((DEPTH_C - cnt) >= FW_C) && !halt_seen;
  assign enq_fire = ready && !bus.flush;
  assign bus.in_ready = ready;
  assign bus.count    = cnt;

  // compaction: each kept lane lands at tail + (kept lanes below it); a halt
  // lane is kept but fences off every higher lane of the group
  always_comb begin
    keep    = '0;
    keep_n  = '0;
    halt_in = 1'b0;
    blocked = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_ptr[i] = tail + PTR_W'(keep_n);
      if (bus.in_valid[i] && !blocked) begin
        keep[i] = 1'b1;
        keep_n  = keep_n + CNT_W'(1);
        if (dec_pkt[i].halt) begin
          blocked = 1'b1;
          halt_in = 1'b1;
        end
      end
    end
  end

  assign enq_n  = enq_fire ? keep_n : '0;
  assign dc_ext = CNT_W'(bus.dispatch_count);
  // over-dispatch is a protocol error; clamp so state stays consistent
  assign deq_n  = (dc_ext > cnt) ? cnt : dc_ext;

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      halt_seen <= 1'b0;
    end else begin
      head <= head + PTR_W'(deq_n);
      tail <= tail + PTR_W'(enq_n);
      cnt  <= cnt + enq_n - deq_n;
      if (enq_fire && halt_in) halt_seen <= 1'b1;
    end
  end

  // payload storage needs no reset: entries are only observed while counted
  always_ff @(posedge clock) begin
    if (!reset && enq_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (keep[i]) mem[wr_ptr[i]] <= dec_pkt[i];
    end
  end

  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      bus.out_valid[k] = cnt > CNT_W'(k);
      bus.out_pkt[k]   = mem[head + PTR_W'(k)];
    end
  end

  a_dispatch_le_count : assert property (
    @(posedge clock) disable iff (reset || bus.flush) dc_ext <= cnt);

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;
  localparam int DC_W  = $clog2(DW + 1);

  localparam int C_UPPER = 0, C_JALR = 1, C_BR = 2, C_LD = 3, C_ST = 4,
                 C_OPIMM = 5, C_OP = 6, C_CSR = 7, C_WFI = 8, C_ILL = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_queue_if #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH)) dq_if ();

  decode_queue #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (dq_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model: a plain queue of expected packets plus the halt fence
  decoded_packet_t mq[$];
  bit              m_halt;
  logic [XLEN-1:0] pc_ctr;

  int              l_cls [FW];
  logic [31:0]     l_inst[FW];
  logic [XLEN-1:0] l_pc  [FW];

  function automatic bit model_ready();
    return ((DEPTH - mq.size()) >= FW) && !m_halt;
  endfunction

  // expected packet follows from the instruction class the bench chose
  function automatic decoded_packet_t exp_pkt(input int cls, input logic [31:0] inst,
                                              input logic [XLEN-1:0] pc);
    decoded_packet_t p;
    p      = '0;
    p.pc   = pc;
    p.npc  = pc + 32'd4;
    p.inst = inst;
    case (cls)
      C_UPPER: p.dest = inst[11:7];
      C_JALR:  begin p.dest = inst[11:7]; p.src1 = inst[19:15]; end
      C_BR:    begin p.is_branch = 1'b1; p.src1 = inst[19:15]; p.src2 = inst[24:20]; end
      C_LD:    begin p.ld_st = LD_ST_LOAD; p.dest = inst[11:7]; p.src1 = inst[19:15]; end
      C_ST:    begin p.ld_st = LD_ST_STORE; p.src1 = inst[19:15]; p.src2 = inst[24:20]; end
      C_OPIMM: begin p.dest = inst[11:7]; p.src1 = inst[19:15]; end
      C_OP:    begin p.dest = inst[11:7]; p.src1 = inst[19:15]; p.src2 = inst[24:20]; end
      C_CSR:   ;
      C_WFI:   p.halt = 1'b1;
      default: p.illegal = 1'b1;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] gen_inst(input int cls);
    logic [4:0]  rd  = 5'($urandom);
    logic [4:0]  rs1 = 5'($urandom);
    logic [4:0]  rs2 = 5'($urandom);
    logic [31:0] r   = $urandom;
    logic [2:0]  f3;
    logic [6:0]  f7;
    case (cls)
      C_UPPER: begin
        case ($urandom_range(0, 2))
          0:       return {r[31:12], rd, 7'b0110111};
          1:       return {r[31:12], rd, 7'b0010111};
          default: return {r[31:12], rd, 7'b1101111};
        endcase
      end
      C_JALR: return {r[31:20], rs1, 3'b000, rd, 7'b1100111};
      C_BR: begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd2) f3 = f3 + 3'd2;
        return {r[31:25], rs2, rs1, f3, r[11:7], 7'b1100011};
      end
      C_LD: begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 >= 3'd3) f3 = f3 + 3'd1;
        return {r[31:20], rs1, f3, rd, 7'b0000011};
      end
      C_ST: begin
        f3 = 3'($urandom_range(0, 2));
        return {r[31:25], rs2, rs1, f3, r[11:7], 7'b0100011};
      end
      C_OPIMM: begin
        f3 = 3'($urandom);
        if (f3 == 3'd1)      f7 = 7'h00;
        else if (f3 == 3'd5) f7 = r[0] ? 7'h20 : 7'h00;
        else                 f7 = r[31:25];
        return {f7, r[24:20], rs1, f3, rd, 7'b0010011};
      end
      C_OP: begin
        f3 = 3'($urandom);
        case ($urandom_range(0, 2))
          0:       f7 = 7'h00;
          1:       begin f7 = 7'h20; f3 = r[0] ? 3'd5 : 3'd0; end
          default: f7 = 7'h01;
        endcase
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
      end
      C_CSR: begin
        f3 = 3'($urandom_range(1, 3));
        return {r[31:20], rs1, f3, rd, 7'b1110011};
      end
      C_WFI: return 32'h1050_0073;
      default: begin
        case ($urandom_range(0, 3))
          0:       return 32'hFFFF_FFFF;
          1:       return 32'h0000_0000;
          2:       return 32'h0000_000F;
          default: return {r[31:7], 7'b1111111};
        endcase
      end
    endcase
  endfunction

  function automatic int rand_cls(input bit allow_halt);
    int w = $urandom_range(0, 99);
    if (allow_halt && w < 4) return C_WFI;
    if (w < 10) return C_ILL;
    return $urandom_range(C_UPPER, C_CSR);
  endfunction

  task automatic set_lane(input int i, input int cls, input logic [31:0] inst);
    l_cls[i]  = cls;
    l_inst[i] = inst;
    l_pc[i]   = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
  endtask

  task automatic rand_lanes(input bit allow_halt);
    int c;
    for (int i = 0; i < FW; i++) begin
      c = rand_cls(allow_halt);
      set_lane(i, c, gen_inst(c));
    end
  endtask

  task automatic check_all();
    chk("count", 128'(dq_if.count), 128'(mq.size()));
    chk("in_ready", 128'(dq_if.in_ready), 128'(model_ready()));
    for (int k = 0; k < DW; k++) begin
      chk($sformatf("out_valid%0d", k), 128'(dq_if.out_valid[k]), 128'(k < mq.size()));
      if (k < mq.size()) chk($sformatf("pkt%0d", k), 128'(dq_if.out_pkt[k]), 128'(mq[k]));
    end
  endtask

  // one clock: drive, update the model across the edge, check at negedge
  task automatic step(input logic [FW-1:0] v, input int dc, input bit fl, input bit rs);
    bit rdy = model_ready();
    rst                  = rs;
    dq_if.flush          = fl;
    dq_if.in_valid       = v;
    dq_if.dispatch_count = DC_W'(dc);
    for (int i = 0; i < FW; i++) begin
      dq_if.in_pc[i]   = l_pc[i];
      dq_if.in_inst[i] = l_inst[i];
    end
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
      m_halt = 1'b0;
    end else begin
      for (int k = 0; k < dc; k++) void'(mq.pop_front());
      if (rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (v[i]) begin
            mq.push_back(exp_pkt(l_cls[i], l_inst[i], l_pc[i]));
            if (l_cls[i] == C_WFI) begin
              m_halt = 1'b1;
              break;
            end
          end
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  int dcr, lim;

  initial begin
    pc_ctr = '0;
    m_halt = 1'b0;
    rand_lanes(1'b0);
    step('0, 0, 1'b0, 1'b1);
    step('0, 0, 1'b0, 1'b1);
    chk("rst_count", 128'(dq_if.count), 128'(0));
    chk("rst_ready", 128'(dq_if.in_ready), 128'(1));

    // ADDI x1,x2,5 @0 ; SW x3,4(x4) @4
    pc_ctr = '0;
    set_lane(0, C_OPIMM, {12'd5, 5'd2, 3'b000, 5'd1, 7'h13});
    set_lane(1, C_ST,    {7'd0, 5'd3, 5'd4, 3'b010, 5'd4, 7'h23});
    step(2'b11, 0, 1'b0, 1'b0);
    chk("t1_valid", 128'(dq_if.out_valid), 128'(2'b11));
    chk("t1_dest0", 128'(dq_if.out_pkt[0].dest), 128'(1));
    chk("t1_src10", 128'(dq_if.out_pkt[0].src1), 128'(2));
    chk("t1_npc0",  128'(dq_if.out_pkt[0].npc), 128'(32'h4));
    chk("t1_ldst1", 128'(dq_if.out_pkt[1].ld_st), 128'(2'b01));
    chk("t1_src21", 128'(dq_if.out_pkt[1].src2), 128'(3));

    // sparse lane: only lane 1 valid with LW x5,0(x6); drain the first two
    set_lane(0, C_ILL, 32'hFFFF_FFFF);
    set_lane(1, C_LD, {12'd0, 5'd6, 3'b010, 5'd5, 7'h03});
    step(2'b10, 2, 1'b0, 1'b0);
    chk("t2_count", 128'(dq_if.count), 128'(1));
    chk("t2_ldst",  128'(dq_if.out_pkt[0].ld_st), 128'(2'b10));
    chk("t2_dest",  128'(dq_if.out_pkt[0].dest), 128'(5));

    // fill until back-pressure
    for (int n = 0; n < 10 && model_ready(); n++) begin
      rand_lanes(1'b0);
      step(2'b11, 0, 1'b0, 1'b0);
    end
    chk("fill_count", 128'(dq_if.count), 128'(7));
    chk("fill_ready", 128'(dq_if.in_ready), 128'(0));
    rand_lanes(1'b0);
    step(2'b11, 1, 1'b0, 1'b0);
    rand_lanes(1'b0);
    step(2'b11, 2, 1'b0, 1'b0);
    chk("steady6", 128'(dq_if.count), 128'(6));

    // wrap-around traffic
    for (int n = 0; n < 20; n++) begin
      rand_lanes(1'b0);
      lim = (mq.size() < DW) ? mq.size() : DW;
      step(2'($urandom), $urandom_range(0, lim), 1'b0, 1'b0);
    end

    // halt fence: WFI in lane 0 drops ADD in lane 1
    step('0, 0, 1'b1, 1'b0);
    set_lane(0, C_WFI, 32'h1050_0073);
    set_lane(1, C_OP, {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33});
    step(2'b11, 0, 1'b0, 1'b0);
    chk("halt_count", 128'(dq_if.count), 128'(1));
    chk("halt_ready", 128'(dq_if.in_ready), 128'(0));
    chk("halt_bit",   128'(dq_if.out_pkt[0].halt), 128'(1));
    rand_lanes(1'b0);
    step(2'b11, 0, 1'b0, 1'b0);
    chk("halt_hold", 128'(dq_if.count), 128'(1));
    step('0, 0, 1'b1, 1'b0);
    chk("flush_ready", 128'(dq_if.in_ready), 128'(1));

    // flush alongside valid input and dispatch
    rand_lanes(1'b0);
    step(2'b11, 0, 1'b0, 1'b0);
    rand_lanes(1'b0);
    step(2'b11, 2, 1'b1, 1'b0);
    chk("flush_count", 128'(dq_if.count), 128'(0));

    // illegal instruction does not stall the queue
    set_lane(0, C_ILL, 32'hFFFF_FFFF);
    set_lane(1, C_OPIMM, {12'd7, 5'd3, 3'b000, 5'd9, 7'h13});
    step(2'b11, 0, 1'b0, 1'b0);
    chk("ill_flag0", 128'(dq_if.out_pkt[0].illegal), 128'(1));
    chk("ill_flag1", 128'(dq_if.out_pkt[1].illegal), 128'(0));
    step('0, 2, 1'b0, 1'b0);

    // random traffic, PCs crossing the 2^XLEN wrap
    pc_ctr = 32'hFFFF_FFF0;
    for (int n = 0; n < 400; n++) begin
      bit fl, rs;
      rand_lanes(1'b1);
      lim = (mq.size() < DW) ? mq.size() : DW;
      dcr = $urandom_range(0, lim);
      fl  = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      rs  = ($urandom_range(0, 199) == 0);
      step(2'($urandom), dcr, fl, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
